wb_simple_bridge: RTL and testbench
===================================

# wb_simple_bridge

Parametrised bridge between one OR1K-style Wishbone B3 master port (instruction or data) and the simple cs/ack memory bus used by the rest of the design. Generalises the current per-port glue: configurable address/data width, Wishbone incrementing-burst support with wrap modes, a slave-timeout that reports a bus error, and safe handling of cycles the master abandons. One instance sits between each CPU bus master and the system arbiter.

## Interface
- AW, 24: simple-bus address width; `adr` = low AW bits of the byte address.
- DW, 32: data width; must be 32 or 64. Beat size is DW/8 bytes and `sel`/`wb_sel_i` are DW/8 bits.
- TIMEOUT, 255: maximum cycles `cs` may wait for `ack`; 0 disables the timeout. Counter width is clog2(TIMEOUT+1).
- BURST_EN, 1: 1 honours cti=3'b010 bursts; 0 treats every access as classic.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wb_adr_i  in  32  byte address.
- wb_dat_i  in  DW  write data.
- wb_sel_i  in  DW/8  byte lanes.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_stb_i  in  1  Wishbone strobe.
- wb_cti_i  in  3  cycle type (000 classic, 010 incrementing, 111 end of burst).
- wb_bte_i  in  2  burst type (00 linear, 01 4-beat wrap, 10 8-beat wrap, 11 16-beat wrap).
- wb_dat_o  out  DW  read data, registered.
- wb_ack_o  out  1  one-cycle acknowledge.
- wb_err_o  out  1  one-cycle error (timeout).
- cs  out  1  simple-bus request.
- we  out  1  simple-bus write.
- sel  out  DW/8  simple-bus byte lanes.
- adr  out  AW  simple-bus address.
- dat_w  out  DW  simple-bus write data.
- dat_r  in  DW  simple-bus read data; valid when `ack` is high.
- ack  in  1  simple-bus acknowledge; only meaningful while `cs` is high.

## Operation
- FSM states:
  - IDLE: cs=0.
  - REQ: cs=1, waiting for ack.
  - RESP: one cycle, cs=0, wb_ack_o or wb_err_o high.
  - DRAIN: cs=1 after the master has dropped cyc.
- IDLE→REQ on cyc&stb. Latch adr, we, sel, dat_w, cti and bte from the wb inputs, clear the timeout counter, set `burst` = BURST_EN & (cti==010).
- REQ→RESP on ack. Register dat_r into wb_dat_o; pulse wb_ack_o next cycle.
- REQ→RESP on timeout (counter == TIMEOUT-1, no ack, TIMEOUT≠0). Drop cs; pulse wb_err_o; wb_dat_o is unchanged.
- REQ→DRAIN if cyc falls while in REQ. The slave transfer cannot be aborted, so cs stays high until ack or timeout, then the FSM goes to IDLE with no wb_ack_o/wb_err_o.
- RESP exit:
  - If `burst` is set, the ack was not an error, and cyc&stb are still high: go to REQ with the next beat. Next address = latched byte address + DW/8, wrapped within a 4, 8 or 16-beat boundary per bte (00 is linear, carries into upper bits). we and sel are held; dat_w and cti are resampled from the wb inputs. wb_adr_i is ignored for continuation beats.
  - A beat whose latched cti==111 ends the burst.
  - Otherwise go to IDLE.
- Every latched address is truncated to AW bits on `adr`.
- If ack and timeout expiry occur in the same cycle, ack wins.

## Timing
- Reset values (async on rst_n low): cs=0, we=0, sel=0, adr=0, dat_w=0, wb_dat_o=0, wb_ack_o=0, wb_err_o=0, FSM=IDLE, counter=0. Asserting rst_n mid-transfer drops cs immediately.
- All outputs are registered.
- Single access:
  - stb seen at cycle 0 → cs high from cycle 1.
  - ack at cycle k → wb_ack_o and wb_dat_o valid at cycle k+1, cs low at k+1.
  - Zero-wait slave: ack at 1, wb_ack_o at 2.
- Burst beats are issued every 2 cycles minimum: cs is low for exactly the one RESP cycle between beats.
- wb_ack_o is never high while cyc is low.
- At most one of wb_ack_o and wb_err_o is high in any cycle.

## Test plan
- Single read, zero-wait slave, wb_adr_i=0x0000_1234, dat_r=0xCAFEBABE → cs cycles 1..1, adr=0x001234, wb_ack_o at cycle 2 with wb_dat_o=0xCAFEBABE, cs=0 at cycle 2.
- Single write, 3-wait slave, sel=4'b0011, dat=0x55AA → we=1, sel=0011, dat_w=0x55AA held for 4 cycles; exactly one wb_ack_o.
- 4-beat wrap read burst (cti=010, bte=01) starting at 0x18, DW=32 → adr sequence 0x18, 0x1C, 0x10, 0x14; last beat cti=111; FSM in IDLE after the 4th ack.
- Timeout: TIMEOUT=8, slave never acks → cs high for exactly 8 cycles, then one wb_err_o pulse, no wb_ack_o, FSM in IDLE.
- Abandoned cycle: cyc drops 2 cycles into REQ, slave acks 3 cycles later → cs stays high until ack, no wb_ack_o, next request accepted normally.
- rst_n low during REQ → cs, wb_ack_o and wb_err_o all 0 immediately; after release a fresh read completes with correct data.

Source files
------------

// File: rtl/wb_simple_bridge.sv
// Wishbone B3 (OR1K-style) master port to simple cs/ack memory bus bridge.
// Supports incrementing/wrapping bursts, slave timeout with bus error, and abandoned cycles.
module wb_simple_bridge #(
    parameter int unsigned AW       = 24,
    parameter int unsigned DW       = 32,
    parameter int unsigned TIMEOUT  = 255,
    parameter bit          BURST_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     wb_adr_i,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic [DW/8-1:0] wb_sel_i,
    input  logic            wb_we_i,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    input  logic [2:0]      wb_cti_i,
    input  logic [1:0]      wb_bte_i,
    output logic [DW-1:0]   wb_dat_o,
    output logic            wb_ack_o,
    output logic            wb_err_o,
    output logic            cs,
    output logic            we,
    output logic [DW/8-1:0] sel,
    output logic [AW-1:0]   adr,
    output logic [DW-1:0]   dat_w,
    input  logic [DW-1:0]   dat_r,
    input  logic            ack
);

    localparam int unsigned    SW      = DW / 8;
    localparam int unsigned    CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [31:0]    BEAT    = 32'(SW);
    localparam logic [CW-1:0]  TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {StIdle, StReq, StResp, StDrain} state_e;

    state_e          state_q, state_d;
    logic [31:0]     adr_q, adr_d;
    logic            we_q, we_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [DW-1:0]   dat_w_q, dat_w_d;
    logic [2:0]      cti_q, cti_d;
    logic [1:0]      bte_q, bte_d;
    logic            burst_q, burst_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   wb_dat_q, wb_dat_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic            cs_q, cs_d;

    logic            timeout_hit;
    logic [31:0]     adr_inc;
    logic [31:0]     wrap_mask;
    logic [31:0]     next_adr;

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    // Wrapping keeps the bits above the wrap boundary; linear lets the carry propagate.
    always_comb begin
        adr_inc = adr_q + BEAT;
        case (bte_q)
            2'b01:   wrap_mask = (BEAT << 2) - 32'd1;
            2'b10:   wrap_mask = (BEAT << 3) - 32'd1;
            2'b11:   wrap_mask = (BEAT << 4) - 32'd1;
            default: wrap_mask = 32'hFFFF_FFFF;
        endcase
        next_adr = (adr_q & ~wrap_mask) | (adr_inc & wrap_mask);
    end

    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        we_d     = we_q;
        sel_d    = sel_q;
        dat_w_d  = dat_w_q;
        cti_d    = cti_q;
        bte_d    = bte_q;
        burst_d  = burst_q;
        cnt_d    = cnt_q;
        wb_dat_d = wb_dat_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (wb_cyc_i && wb_stb_i) begin
                    state_d = StReq;
                    adr_d   = wb_adr_i;
                    we_d    = wb_we_i;
                    sel_d   = wb_sel_i;
                    dat_w_d = wb_dat_i;
                    cti_d   = wb_cti_i;
                    bte_d   = wb_bte_i;
                    burst_d = BURST_EN && (wb_cti_i == 3'b010);
                    cnt_d   = '0;
                end
            end
            StReq: begin
                cnt_d = cnt_q + 1'b1;
                if (!wb_cyc_i) begin
                    // Master gave up: the slave access still has to finish silently.
                    state_d = (ack || timeout_hit) ? StIdle : StDrain;
                end else if (ack) begin
                    state_d  = StResp;
                    wb_dat_d = dat_r;
                    ack_d    = 1'b1;
                end else if (timeout_hit) begin
                    state_d = StResp;
                    err_d   = 1'b1;
                end
            end
            StResp: begin
                if (burst_q && !err_q && (cti_q != 3'b111) && wb_cyc_i && wb_stb_i) begin
                    state_d = StReq;
                    adr_d   = next_adr;
                    dat_w_d = wb_dat_i;
                    cti_d   = wb_cti_i;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                cnt_d = cnt_q + 1'b1;
                if (ack || timeout_hit) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        cs_d = (state_d == StReq) || (state_d == StDrain);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            adr_q    <= '0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            dat_w_q  <= '0;
            cti_q    <= '0;
            bte_q    <= '0;
            burst_q  <= 1'b0;
            cnt_q    <= '0;
            wb_dat_q <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            cs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            dat_w_q  <= dat_w_d;
            cti_q    <= cti_d;
            bte_q    <= bte_d;
            burst_q  <= burst_d;
            cnt_q    <= cnt_d;
            wb_dat_q <= wb_dat_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            cs_q     <= cs_d;
        end
    end

    assign cs       = cs_q;
    assign we       = we_q;
    assign sel      = sel_q;
    assign adr      = adr_q[AW-1:0];
    assign dat_w    = dat_w_q;
    assign wb_dat_o = wb_dat_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;

endmodule

// File: tb/tb_wb_simple_bridge.sv
// Randomized self-checking bench for wb_simple_bridge: bus master plus memory slave in one thread,
// checked against a transaction-level address/data model.
module tb_wb_simple_bridge;

    localparam int unsigned AW = 24;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   wb_adr_i;
    logic [DW-1:0] wb_dat_i;
    logic [3:0]    wb_sel_i;
    logic          wb_we_i;
    logic          wb_cyc_i;
    logic          wb_stb_i;
    logic [2:0]    wb_cti_i;
    logic [1:0]    wb_bte_i;
    logic [DW-1:0] wb_dat_o;
    logic          wb_ack_o;
    logic          wb_err_o;
    logic          cs;
    logic          we;
    logic [3:0]    sel;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat_w;
    logic [DW-1:0] dat_r;
    logic          ack;

    always #5 clk = ~clk;

    wb_simple_bridge #(
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TO),
        .BURST_EN(1'b1)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wb_adr_i(wb_adr_i),
        .wb_dat_i(wb_dat_i),
        .wb_sel_i(wb_sel_i),
        .wb_we_i (wb_we_i),
        .wb_cyc_i(wb_cyc_i),
        .wb_stb_i(wb_stb_i),
        .wb_cti_i(wb_cti_i),
        .wb_bte_i(wb_bte_i),
        .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack_o),
        .wb_err_o(wb_err_o),
        .cs      (cs),
        .we      (we),
        .sel     (sel),
        .adr     (adr),
        .dat_w   (dat_w),
        .dat_r   (dat_r),
        .ack     (ack)
    );

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] mem [int unsigned];
    logic [31:0] last_rd;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_rd(input logic [AW-1:0] a);
        logic [31:0] k;
        k = 32'(a) >> 2;
        if (mem.exists(k)) return mem[k];
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic mem_wr(input logic [AW-1:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] v;
        logic [31:0] k;
        k = 32'(a) >> 2;
        v = mem_rd(a);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) v[8*b +: 8] = d[8*b +: 8];
        end
        mem[k] = v;
    endtask

    // Byte address of beat i of a burst, from the wrap-span arithmetic.
    function automatic logic [31:0] beat_addr(input logic [31:0] a0, input logic [1:0] bte,
                                              input int i);
        logic [31:0] span;
        case (bte)
            2'b01:   span = 32'd16;
            2'b10:   span = 32'd32;
            2'b11:   span = 32'd64;
            default: span = 32'd0;
        endcase
        if (span == 32'd0) return a0 + 32'(4 * i);
        return (a0 - (a0 % span)) + (((a0 % span) + 32'(4 * i)) % span);
    endfunction

    task automatic do_xfer(input logic [31:0] a0, input logic w, input logic [3:0] s,
                           input int nb, input logic [1:0] bte, input logic [31:0] wd0,
                           input int min_wait, input int max_wait);
        logic [31:0]   wd;
        logic [31:0]   ea;
        logic [AW-1:0] eadr;
        logic [31:0]   exp_rd;
        int            waits;
        wd       = wd0;
        wb_adr_i = a0;
        wb_we_i  = w;
        wb_sel_i = s;
        wb_dat_i = wd;
        wb_bte_i = bte;
        wb_cti_i = (nb == 1) ? 3'b000 : ((nb == 1) ? 3'b111 : 3'b010);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        dat_r    = $urandom;
        step();
        for (int i = 0; i < nb; i++) begin
            ea     = beat_addr(a0, bte, i);
            eadr   = ea[AW-1:0];
            exp_rd = mem_rd(eadr);
            waits  = int'($urandom_range(max_wait, min_wait));
            for (int k = 0; k <= waits; k++) begin
                check_eq("cs_req", 64'(cs), 64'd1);
                check_eq("adr", 64'(adr), 64'(eadr));
                check_eq("we", 64'(we), 64'(w));
                check_eq("sel", 64'(sel), 64'(s));
                check_eq("dat_w", 64'(dat_w), 64'(wd));
                check_eq("ack_o_wait", 64'(wb_ack_o), 64'd0);
                if (k == waits) begin
                    ack     = 1'b1;
                    dat_r   = mem_rd(adr);
                    last_rd = dat_r;
                    if (we) mem_wr(adr, sel, dat_w);
                end
                step();
                ack   = 1'b0;
                dat_r = $urandom;
            end
            check_eq("ack_o", 64'(wb_ack_o), 64'd1);
            check_eq("err_o", 64'(wb_err_o), 64'd0);
            check_eq("cs_resp", 64'(cs), 64'd0);
            if (!w) check_eq("rd_data", 64'(wb_dat_o), 64'(exp_rd));
            if (i < nb - 1) begin
                wd       = $urandom;
                wb_dat_i = wd;
                wb_adr_i = $urandom;
                wb_cti_i = (i + 1 == nb - 1) ? 3'b111 : 3'b010;
            end
            step();
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_cti_i = 3'b000;
        check_eq("cs_idle", 64'(cs), 64'd0);
        check_eq("ack_o_idle", 64'(wb_ack_o), 64'd0);
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int          hi;
        logic [31:0] a;
        int          nb;
        rst_n    = 1'b0;
        wb_adr_i = '0;
        wb_dat_i = '0;
        wb_sel_i = '0;
        wb_we_i  = 1'b0;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_cti_i = '0;
        wb_bte_i = '0;
        dat_r    = '0;
        ack      = 1'b0;
        last_rd  = '0;
        step();
        step();
        check_eq("rst_cs", 64'(cs), 64'd0);
        check_eq("rst_we", 64'(we), 64'd0);
        check_eq("rst_sel", 64'(sel), 64'd0);
        check_eq("rst_adr", 64'(adr), 64'd0);
        check_eq("rst_dat_w", 64'(dat_w), 64'd0);
        check_eq("rst_dat_o", 64'(wb_dat_o), 64'd0);
        check_eq("rst_ack_o", 64'(wb_ack_o), 64'd0);
        check_eq("rst_err_o", 64'(wb_err_o), 64'd0);
        rst_n = 1'b1;
        step();

        // Zero-wait single read, 3-wait single write, then read-back of the merged lanes.
        mem[32'h1234 >> 2] = 32'hCAFE_BABE;
        do_xfer(32'h0000_1234, 1'b0, 4'hF, 1, 2'b00, 32'h0, 0, 0);
        do_xfer(32'h0000_0040, 1'b1, 4'b0011, 1, 2'b00, 32'h0000_55AA, 3, 3);
        do_xfer(32'h0000_0040, 1'b0, 4'hF, 1, 2'b00, 32'h0, 0, 2);
        // 4-beat wrap read starting mid-line, then a 16-beat wrap write and linear read.
        do_xfer(32'h0000_0018, 1'b0, 4'hF, 4, 2'b01, 32'h0, 0, 2);
        do_xfer(32'h0000_0134, 1'b1, 4'hF, 16, 2'b11, $urandom, 0, 1);
        do_xfer(32'h0000_0100, 1'b0, 4'hF, 20, 2'b00, 32'h0, 0, 1);

        // Slave never answers.
        wb_adr_i = 32'h0000_0300;
        wb_we_i  = 1'b0;
        wb_sel_i = 4'hF;
        wb_cti_i = 3'b000;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        step();
        hi = 0;
        while (cs && hi < 20) begin
            check_eq("to_ack_wait", 64'(wb_ack_o | wb_err_o), 64'd0);
            hi++;
            step();
        end
        check_eq("to_cycles", 64'(hi), 64'(TO));
        check_eq("to_err", 64'(wb_err_o), 64'd1);
        check_eq("to_ack", 64'(wb_ack_o), 64'd0);
        check_eq("to_dat", 64'(wb_dat_o), 64'(last_rd));
        step();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        check_eq("to_err_done", 64'(wb_err_o), 64'd0);
        check_eq("to_cs_done", 64'(cs), 64'd0);
        step();

        // Master abandons the cycle two cycles into the request.
        wb_adr_i = 32'h0000_0200;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        step();
        check_eq("ab_cs1", 64'(cs), 64'd1);
        step();
        check_eq("ab_cs2", 64'(cs), 64'd1);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check_eq("ab_cs_drain", 64'(cs), 64'd1);
            check_eq("ab_ack_drain", 64'(wb_ack_o), 64'd0);
        end
        ack   = 1'b1;
        dat_r = $urandom;
        step();
        ack = 1'b0;
        check_eq("ab_cs_end", 64'(cs), 64'd0);
        check_eq("ab_resp_end", 64'(wb_ack_o | wb_err_o), 64'd0);
        check_eq("ab_dat", 64'(wb_dat_o), 64'(last_rd));
        step();
        check_eq("ab_ack_after", 64'(wb_ack_o), 64'd0);
        do_xfer(32'h0000_0204, 1'b0, 4'hF, 1, 2'b00, 32'h0, 0, 3);

        // Reset asserted while a request is outstanding.
        wb_adr_i = 32'h0000_0400;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_cs", 64'(cs), 64'd0);
        check_eq("rst_mid_ack", 64'(wb_ack_o), 64'd0);
        check_eq("rst_mid_err", 64'(wb_err_o), 64'd0);
        last_rd  = '0;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        do_xfer(32'h0000_0400, 1'b0, 4'hF, 1, 2'b00, 32'h0, 0, 3);

        // Random mix of classic and burst transfers of every wrap type.
        for (int t = 0; t < 30; t++) begin
            a  = $urandom & 32'hFFFF_FFFC;
            nb = ($urandom_range(2, 0) == 0) ? 1 : int'($urandom_range(9, 2));
            do_xfer(a, 1'($urandom_range(1, 0)), 4'($urandom_range(15, 1)), nb,
                    2'($urandom_range(3, 0)), $urandom, 0, 4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
